// File: rtl/alu_pkg.sv
// Shared definitions for the calculadora front end: opcode encodings,
// sequencer state encoding and the opcode validity check.
package alu_pkg;

   typedef logic [5:0] opcode_t;

   localparam opcode_t OP_ADD = 6'b100000;
   localparam opcode_t OP_SUB = 6'b100010;
   localparam opcode_t OP_AND = 6'b100100;
   localparam opcode_t OP_OR  = 6'b100101;
   localparam opcode_t OP_XOR = 6'b100110;
   localparam opcode_t OP_NOR = 6'b100111;
   localparam opcode_t OP_SRA = 6'b000011;
   localparam opcode_t OP_SRL = 6'b000010;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   // An opcode is accepted only with the two top switches low and a known code below
   function automatic logic opcode_valid(input logic [7:0] code);
      logic ok;
      ok = 1'b0;
      if (code[7:6] == 2'b00) begin
         case (code[5:0])
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
            default:                        ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/boton_edge.sv
// Push-button conditioner: two-flop synchronizer, optional debounce
// (ALU_SEQ_DEBOUNCE_EN) and rising-edge detector producing a one-cycle event.
module boton_edge #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic boton,
   output logic evento
);

   logic sync_1;
   logic sync_2;
   logic nivel;
   logic nivel_prev;

   // Bring the asynchronous button into the clock domain
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= boton;
         sync_2 <= sync_1;
      end
   end

`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cuenta;

   // Accept a new level only after it has been seen on consecutive cycles long enough
   always_ff @(posedge clk) begin
      if (reset) begin
         cuenta <= '0;
         nivel  <= 1'b0;
      end else if (sync_2 == nivel) begin
         cuenta <= '0;
      end else if (cuenta == CW'(DEBOUNCE_CYCLES - 1)) begin
         cuenta <= '0;
         nivel  <= sync_2;
      end else begin
         cuenta <= cuenta + 1'b1;
      end
   end
`else
   logic unused_cfg;

   assign unused_cfg = ^DEBOUNCE_CYCLES;
   assign nivel      = sync_2;
`endif

   // Remember the previous accepted level so a held button fires only once
   always_ff @(posedge clk) begin
      if (reset) begin
         nivel_prev <= 1'b0;
      end else begin
         nivel_prev <= nivel;
      end
   end

   assign evento = nivel & ~nivel_prev;

endmodule

// File: rtl/alu_sequencer.sv
// Front-end sequencer for the calculadora ALU: loads operand A, operand B and
// the opcode from the shared switch bus on button events, runs one execute
// cycle and latches the result. Optional debounce: ALU_SEQ_DEBOUNCE_EN.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] entrada,
   input  logic             boton_a,
   input  logic             boton_b,
   input  logic             boton_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [5:0]       alu_op,
   input  logic [WIDTH-1:0] alu_rdo,
   input  logic             alu_carry,
   input  logic             alu_zero,
   output logic [WIDTH-1:0] rdo,
   output logic             carry,
   output logic             zero,
   output logic             rdo_valid,
   output logic             op_error,
   output logic [2:0]       estado
);

   state_t estado_q;
   state_t estado_d;

   logic ev_a;
   logic ev_b;
   logic ev_op;

   logic load_a;
   logic load_b;
   logic load_op;
   logic set_err;
   logic capture;

   boton_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_edge_a (
      .clk    (clk),
      .reset  (reset),
      .boton  (boton_a),
      .evento (ev_a)
   );

   boton_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_edge_b (
      .clk    (clk),
      .reset  (reset),
      .boton  (boton_b),
      .evento (ev_b)
   );

   boton_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_edge_op (
      .clk    (clk),
      .reset  (reset),
      .boton  (boton_op),
      .evento (ev_op)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q <= S_A;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next state and load strobes; events not expected in the current state are dropped
   always_comb begin
      estado_d = estado_q;
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_op  = 1'b0;
      set_err  = 1'b0;
      capture  = 1'b0;
      case (estado_q)
         S_A, S_SHOW: begin
            if (ev_a) begin
               load_a   = 1'b1;
               estado_d = S_B;
            end
         end
         S_B: begin
            if (ev_b) begin
               load_b   = 1'b1;
               estado_d = S_OP;
            end
         end
         S_OP: begin
            if (ev_op) begin
               if (opcode_valid(entrada[7:0])) begin
                  load_op  = 1'b1;
                  estado_d = S_EXEC;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         S_EXEC: begin
            capture  = 1'b1;
            estado_d = S_SHOW;
         end
         default: begin
            estado_d = S_A;
         end
      endcase
   end

   // Operand, opcode, result and flag registers; reset also aborts a pending capture
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rdo       <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         rdo_valid <= 1'b0;
         op_error  <= 1'b0;
      end else begin
         rdo_valid <= capture;
         if (load_a) begin
            alu_a <= entrada;
         end
         if (load_b) begin
            alu_b <= entrada;
         end
         if (load_op) begin
            alu_op   <= entrada[5:0];
            op_error <= 1'b0;
         end else if (set_err) begin
            op_error <= 1'b1;
         end
         if (capture) begin
            rdo   <= alu_rdo;
            carry <= alu_carry;
            zero  <= alu_zero;
         end
      end
   end

   assign estado = estado_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural ALU answers the sequencer, and
// each operation is checked against results computed from the intended operands.
module tb_alu_sequencer;

   localparam int WIDTH = 8;
`ifdef ALU_SEQ_DEBOUNCE_EN
   localparam int HOLD = 24;
`else
   localparam int HOLD = 6;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] entrada;
   logic             boton_a;
   logic             boton_b;
   logic             boton_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [5:0]       alu_op;
   logic [WIDTH-1:0] alu_rdo;
   logic             alu_carry;
   logic             alu_zero;
   logic [WIDTH-1:0] rdo;
   logic             carry;
   logic             zero;
   logic             rdo_valid;
   logic             op_error;
   logic [2:0]       estado;

   int total = 0;
   int bad = 0;
   int pulse_total = 0;

   logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

   alu_sequencer #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .entrada   (entrada),
      .boton_a   (boton_a),
      .boton_b   (boton_b),
      .boton_op  (boton_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_rdo   (alu_rdo),
      .alu_carry (alu_carry),
      .alu_zero  (alu_zero),
      .rdo       (rdo),
      .carry     (carry),
      .zero      (zero),
      .rdo_valid (rdo_valid),
      .op_error  (op_error),
      .estado    (estado)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {zero, carry, result}
   function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      logic [8:0] s;
      s = 9'd0;
      case (op)
         6'h20: s = {1'b0, a} + {1'b0, b};
         6'h22: s = {1'b0, a} - {1'b0, b};
         6'h24: s = {1'b0, a & b};
         6'h25: s = {1'b0, a | b};
         6'h26: s = {1'b0, a ^ b};
         6'h27: s = {1'b0, ~(a | b)};
         6'h03: s = {1'b0, 8'($signed(a) >>> b[2:0])};
         6'h02: s = {1'b0, a >> b[2:0]};
         default: s = 9'd0;
      endcase
      return {(s[7:0] == 8'd0), s[8], s[7:0]};
   endfunction

   // The ALU responds combinationally to whatever the sequencer presents
   always_comb begin
      logic [9:0] r;
      r = alu_model(alu_a, alu_b, alu_op);
      alu_rdo   = r[7:0];
      alu_carry = r[8];
      alu_zero  = r[9];
   end

   // Running count of result-valid cycles
   always @(posedge clk) begin
      if (rdo_valid === 1'b1) pulse_total++;
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Press the buttons in mask {op,b,a} with value on the switches, hold, release, settle
   task automatic apply_stimulus(input logic [2:0] mask, input logic [7:0] value);
      entrada = value;
      @(posedge clk); #1;
      boton_a  = mask[0];
      boton_b  = mask[1];
      boton_op = mask[2];
      repeat (HOLD) @(posedge clk);
      #1;
      boton_a  = 1'b0;
      boton_b  = 1'b0;
      boton_op = 1'b0;
      repeat (HOLD) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Full operation A, B, opcode, then compare everything against the model
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
      int p0;
      logic [9:0] exp;
      exp = alu_model(a, b, op);
      p0 = pulse_total;
      apply_stimulus(3'b001, a);
      apply_stimulus(3'b010, b);
      apply_stimulus(3'b100, {2'b00, op});
      check_output({tag, " alu_a"}, 32'(alu_a), 32'(a));
      check_output({tag, " alu_b"}, 32'(alu_b), 32'(b));
      check_output({tag, " alu_op"}, 32'(alu_op), 32'(op));
      check_output({tag, " rdo"}, 32'(rdo), 32'(exp[7:0]));
      check_output({tag, " carry"}, 32'(carry), 32'(exp[8]));
      check_output({tag, " zero"}, 32'(zero), 32'(exp[9]));
      check_output({tag, " pulses"}, 32'(pulse_total - p0), 32'd1);
      check_output({tag, " estado"}, 32'(estado), 32'd4);
   endtask

   initial begin
      int p0;
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] bad_code;

      reset    = 1'b1;
      entrada  = '0;
      boton_a  = 1'b0;
      boton_b  = 1'b0;
      boton_op = 1'b0;
      do_reset(3);

      check_output("reset estado", 32'(estado), 32'd0);
      check_output("reset alu_a", 32'(alu_a), 32'd0);
      check_output("reset alu_b", 32'(alu_b), 32'd0);
      check_output("reset alu_op", 32'(alu_op), 32'd0);
      check_output("reset rdo", 32'(rdo), 32'd0);
      check_output("reset flags", 32'({carry, zero, rdo_valid, op_error}), 32'd0);

      run_op("add7+5", 8'd7, 8'd5, 6'h20);
      check_output("add7+5 rdo const", 32'(rdo), 32'd12);
      run_op("add200+100", 8'd200, 8'd100, 6'h20);
      check_output("add200+100 rdo const", 32'(rdo), 32'd44);
      check_output("add200+100 carry const", 32'(carry), 32'd1);
      run_op("sub5-5", 8'd5, 8'd5, 6'h22);
      check_output("sub5-5 zero const", 32'(zero), 32'd1);

      // Rejected opcode, then a good one
      p0 = pulse_total;
      apply_stimulus(3'b001, 8'h3C);
      apply_stimulus(3'b010, 8'h0F);
      apply_stimulus(3'b100, 8'hFF);
      check_output("err op_error", 32'(op_error), 32'd1);
      check_output("err estado", 32'(estado), 32'd2);
      check_output("err alu_op kept", 32'(alu_op), 32'h22);
      check_output("err no pulse", 32'(pulse_total - p0), 32'd0);
      apply_stimulus(3'b100, 8'h24);
      check_output("err cleared", 32'(op_error), 32'd0);
      check_output("err and rdo", 32'(rdo), 32'h0C);
      check_output("err one pulse", 32'(pulse_total - p0), 32'd1);

      // Simultaneous A and B in S_A: only A is accepted
      do_reset(1);
      apply_stimulus(3'b011, 8'd9);
      check_output("simul alu_a", 32'(alu_a), 32'd9);
      check_output("simul alu_b", 32'(alu_b), 32'd0);
      check_output("simul estado", 32'(estado), 32'd1);

      // Reset while waiting for B
      do_reset(1);
      check_output("rstB estado", 32'(estado), 32'd0);
      check_output("rstB alu_a", 32'(alu_a), 32'd0);
      check_output("rstB outputs", 32'({alu_b, alu_op, rdo, carry, zero, rdo_valid, op_error}), 32'd0);

      // Randomized operations, with an occasional rejected opcode mixed in
      for (int i = 0; i < 16; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ((i % 5) == 4) begin
            apply_stimulus(3'b001, ra);
            apply_stimulus(3'b010, rb);
            bad_code = 8'($urandom) | 8'h40;
            apply_stimulus(3'b100, bad_code);
            check_output("rand reject", 32'({estado, op_error}), 32'({3'd2, 1'b1}));
            apply_stimulus(3'b100, {2'b00, valid_ops[i % 8]});
            check_output("rand recover rdo", 32'(rdo), 32'(alu_model(ra, rb, valid_ops[i % 8]) & 10'h0FF));
            check_output("rand recover err", 32'(op_error), 32'd0);
         end else begin
            run_op("rand", ra, rb, valid_ops[$urandom_range(0, 7)]);
         end
      end

`ifdef ALU_SEQ_DEBOUNCE_EN
      // A short glitch must not load; a long press must
      do_reset(1);
      entrada = 8'h55;
      boton_a = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      boton_a = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check_output("glitch alu_a", 32'(alu_a), 32'd0);
      check_output("glitch estado", 32'(estado), 32'd0);
      apply_stimulus(3'b001, 8'h55);
      check_output("debounce alu_a", 32'(alu_a), 32'h55);
      check_output("debounce estado", 32'(estado), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
